// File: rtl/ov7670_gray_frame_writer.sv
// ============================================================================
// Module  : ov7670_gray_frame_writer
// Brief   : RGB565 pixel stream -> 8-bit luma frame buffer writer with frame
//           arming, discontinuity drop and ready/ack handshake.
//           Optional macro BINARIZE_EN: output 8'hFF/8'h00 against BIN_THRESHOLD.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ov7670_gray_frame_writer #(
  parameter int IMG_WIDTH     = 320,
  parameter int IMG_HEIGHT    = 240,
  parameter int ADDR_WIDTH    = $clog2(IMG_WIDTH*IMG_HEIGHT),
  parameter int BIN_THRESHOLD = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_we,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [15:0]           in_data,
  input  logic                  frame_ack,
  output logic                  gray_we,
  output logic [ADDR_WIDTH-1:0] gray_addr,
  output logic [7:0]            gray_data,
  output logic                  frame_ready,
  output logic [7:0]            frame_cnt,
  output logic                  pix_err
);

  localparam logic [ADDR_WIDTH-1:0] c_one  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] c_last = ADDR_WIDTH'(IMG_WIDTH*IMG_HEIGHT-1);

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_expected;
  logic                  w_accept;

  logic [7:0]            w_r8, w_g8, w_b8;
  logic                  r_s1_valid;
  logic [ADDR_WIDTH-1:0] r_s1_addr;
  logic [15:0]           r_s1_pr, r_s1_pg, r_s1_pb;
  logic [16:0]           w_sum;
  logic [8:0]            w_y;
  logic [7:0]            w_gray;

  // Restart on address 0 is accepted mid-capture as well as in ARMED.
  always_comb begin
    w_accept = 1'b0;
    case (r_state)
      ST_ARMED:   w_accept = in_we && (in_addr == '0);
      ST_CAPTURE: w_accept = in_we && ((in_addr == r_expected) || (in_addr == '0));
      default:    w_accept = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_ARMED;
      r_expected <= '0;
      frame_cnt  <= 8'd0;
      pix_err    <= 1'b0;
    end else begin
      pix_err <= 1'b0;
      case (r_state)
        ST_ARMED: begin
          if (in_we && (in_addr == '0)) begin
            r_expected <= c_one;
            r_state    <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (in_we) begin
            if (in_addr == r_expected) begin
              r_expected <= r_expected + c_one;
              if (in_addr == c_last) begin
                r_state   <= ST_READY;
                frame_cnt <= frame_cnt + 8'd1;
              end
            end else if (in_addr == '0) begin
              r_expected <= c_one;
              pix_err    <= 1'b1;
            end else begin
              r_expected <= '0;
              pix_err    <= 1'b1;
              r_state    <= ST_ARMED;
            end
          end
        end
        ST_READY: begin
          if (frame_ack) begin
            r_expected <= '0;
            r_state    <= ST_ARMED;
          end
        end
        default: r_state <= ST_ARMED;
      endcase
    end
  end

  assign w_r8 = {in_data[15:11], in_data[15:13]};
  assign w_g8 = {in_data[10:5],  in_data[10:9]};
  assign w_b8 = {in_data[4:0],   in_data[4:2]};

  assign w_sum = {1'b0, r_s1_pr} + {1'b0, r_s1_pg} + {1'b0, r_s1_pb};
  assign w_y   = 9'(w_sum >> 8);

`ifdef BINARIZE_EN
  assign w_gray = (w_y >= 9'(BIN_THRESHOLD)) ? 8'hFF : 8'h00;
`else
  // Coefficients sum to 256, so w_y never exceeds 255; the clamp is defensive.
  assign w_gray = w_y[8] ? 8'hFF : w_y[7:0];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_pr    <= 16'd0;
      r_s1_pg    <= 16'd0;
      r_s1_pb    <= 16'd0;
      gray_we    <= 1'b0;
      gray_addr  <= '0;
      gray_data  <= 8'd0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_addr  <= in_addr;
      r_s1_pr    <= {8'd0, w_r8} * 16'd77;
      r_s1_pg    <= {8'd0, w_g8} * 16'd150;
      r_s1_pb    <= {8'd0, w_b8} * 16'd29;
      gray_we    <= r_s1_valid;
      gray_addr  <= r_s1_addr;
      gray_data  <= w_gray;
    end
  end

  assign frame_ready = (r_state == ST_READY) && !r_s1_valid && !gray_we;

endmodule

`default_nettype wire

// File: tb/tb_ov7670_gray_frame_writer.sv
// ============================================================================
// Module  : tb_ov7670_gray_frame_writer
// Brief   : Directed self-checking bench for ov7670_gray_frame_writer (4x2 image).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ov7670_gray_frame_writer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_we = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [15:0]   in_data = 16'd0;
  logic          frame_ack = 1'b0;
  logic          gray_we;
  logic [AW-1:0] gray_addr;
  logic [7:0]    gray_data;
  logic          frame_ready;
  logic [7:0]    frame_cnt;
  logic          pix_err;

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt  = 0;
  int pe_cnt  = 0;
  logic [10:0] log_q[$];

  ov7670_gray_frame_writer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(AW), .BIN_THRESHOLD(128)
  ) dut (
    .clk(clk), .reset(reset), .in_we(in_we), .in_addr(in_addr), .in_data(in_data),
    .frame_ack(frame_ack), .gray_we(gray_we), .gray_addr(gray_addr),
    .gray_data(gray_data), .frame_ready(frame_ready), .frame_cnt(frame_cnt),
    .pix_err(pix_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (gray_we) begin
      we_cnt++;
      log_q.push_back({gray_addr, gray_data});
    end
    if (pix_err) pe_cnt++;
  end

  function automatic logic [7:0] exp_gray(input int y);
`ifdef BINARIZE_EN
    return (y >= 128) ? 8'hFF : 8'h00;
`else
    return 8'(y);
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_we = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    in_we   = 1'b1;
    in_addr = AW'(a);
    in_data = d;
    cyc();
    in_we   = 1'b0;
  endtask

  task automatic do_reset();
    in_we = 1'b0;
    frame_ack = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic ack_pulse();
    frame_ack = 1'b1;
    cyc();
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (gray_we !== 1'b0)     begin n_fail++; $display("FAIL rst_gray_we got %b exp 0", gray_we); end
    n_tests++; if (gray_addr !== 3'd0)   begin n_fail++; $display("FAIL rst_gray_addr got %0d exp 0", gray_addr); end
    n_tests++; if (gray_data !== 8'd0)   begin n_fail++; $display("FAIL rst_gray_data got %0d exp 0", gray_data); end
    n_tests++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL rst_frame_ready got %b exp 0", frame_ready); end
    n_tests++; if (frame_cnt !== 8'd0)   begin n_fail++; $display("FAIL rst_frame_cnt got %0d exp 0", frame_cnt); end
    n_tests++; if (pix_err !== 1'b0)     begin n_fail++; $display("FAIL rst_pix_err got %b exp 0", pix_err); end
  endtask

  task automatic test_colour_lut();
    logic [15:0] px [5] = '{16'hFFFF, 16'hF800, 16'h07E0, 16'h001F, 16'h0000};
    int          ly [5] = '{255, 76, 149, 28, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr(0, px[i]);
      n_tests++; if (gray_we !== 1'b0) begin n_fail++; $display("FAIL lut_early_we[%0d] got %b exp 0", i, gray_we); end
      cyc();
      n_tests++; if (gray_we !== 1'b1) begin n_fail++; $display("FAIL lut_we[%0d] got %b exp 1", i, gray_we); end
      n_tests++; if (gray_data !== exp_gray(ly[i])) begin n_fail++; $display("FAIL lut_data[%0d] got %0d exp %0d", i, gray_data, exp_gray(ly[i])); end
      n_tests++; if (gray_addr !== 3'd0) begin n_fail++; $display("FAIL lut_addr[%0d] got %0d exp 0", i, gray_addr); end
      cyc();
      n_tests++; if (gray_we !== 1'b0) begin n_fail++; $display("FAIL lut_late_we[%0d] got %b exp 0", i, gray_we); end
    end
  endtask

  task automatic test_full_frame();
    logic [15:0] px  [8] = '{16'hFFFF, 16'hF800, 16'h07E0, 16'h001F, 16'h0000, 16'h8410, 16'hFFFF, 16'hF800};
    int          ly  [8] = '{255, 76, 149, 28, 0, 130, 255, 76};
    int          gap [8] = '{0, 2, 1, 0, 3, 0, 1, 0};
    int b, bq;
    logic [10:0] expv;
    do_reset();
    b  = we_cnt;
    bq = log_q.size();
    for (int a = 0; a < 8; a++) begin
      wr(a, px[a]);
      idle(gap[a]);
    end
    cyc();
    n_tests++; if (gray_we !== 1'b1 || frame_ready !== 1'b0) begin n_fail++; $display("FAIL ff_last_we got we=%b rdy=%b exp we=1 rdy=0", gray_we, frame_ready); end
    cyc();
    n_tests++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL ff_ready got %b exp 1", frame_ready); end
    n_tests++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL ff_frame_cnt got %0d exp 1", frame_cnt); end
    n_tests++; if (we_cnt - b !== 8) begin n_fail++; $display("FAIL ff_we_count got %0d exp 8", we_cnt - b); end
    for (int i = 0; i < 8; i++) begin
      expv = {3'(i), exp_gray(ly[i])};
      n_tests++;
      if (bq + i >= log_q.size() || log_q[bq + i] !== expv) begin
        n_fail++;
        $display("FAIL ff_pixel[%0d] got %h exp %h", i, (bq + i < log_q.size()) ? log_q[bq + i] : 11'h7FF, expv);
      end
    end
    for (int a = 0; a < 4; a++) wr(a, 16'hFFFF);
    idle(3);
    n_tests++; if (we_cnt - b !== 8) begin n_fail++; $display("FAIL ff_frozen got %0d exp 8", we_cnt - b); end
    n_tests++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL ff_hold_ready got %b exp 1", frame_ready); end
    ack_pulse();
    n_tests++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL ff_ack_drop got %b exp 0", frame_ready); end
    wr(0, 16'hFFFF);
    idle(2);
    n_tests++; if (we_cnt - b !== 9) begin n_fail++; $display("FAIL ff_rearm got %0d exp 9", we_cnt - b); end
  endtask

  task automatic test_ack_on_entry();
    do_reset();
    for (int a = 0; a < 7; a++) wr(a, 16'h0000);
    frame_ack = 1'b1;
    wr(7, 16'h0000);
    frame_ack = 1'b0;
    idle(3);
    n_tests++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL entry_ack_ignored got %b exp 1", frame_ready); end
    ack_pulse();
  endtask

  task automatic test_discontinuity();
    int b, pb;
    do_reset();
    b  = we_cnt;
    pb = pe_cnt;
    wr(0, 16'hFFFF); wr(1, 16'hFFFF); wr(2, 16'hFFFF);
    n_tests++; if (pix_err !== 1'b0) begin n_fail++; $display("FAIL disc_no_err got %b exp 0", pix_err); end
    wr(5, 16'hFFFF);
    n_tests++; if (pix_err !== 1'b1) begin n_fail++; $display("FAIL disc_err_pulse got %b exp 1", pix_err); end
    wr(6, 16'hFFFF); wr(7, 16'hFFFF);
    idle(3);
    n_tests++; if (we_cnt - b !== 3) begin n_fail++; $display("FAIL disc_we_count got %0d exp 3", we_cnt - b); end
    n_tests++; if (pe_cnt - pb !== 1) begin n_fail++; $display("FAIL disc_err_count got %0d exp 1", pe_cnt - pb); end
    n_tests++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL disc_ready got %b exp 0", frame_ready); end
    wr(0, 16'hFFFF);
    idle(3);
    n_tests++; if (we_cnt - b !== 4) begin n_fail++; $display("FAIL disc_restart got %0d exp 4", we_cnt - b); end
  endtask

  task automatic test_restart();
    int seq [11] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 6, 7};
    int b, pb;
    do_reset();
    b  = we_cnt;
    pb = pe_cnt;
    for (int i = 0; i < 11; i++) wr(seq[i], 16'h07E0);
    idle(3);
    n_tests++; if (we_cnt - b !== 11) begin n_fail++; $display("FAIL rs_we_count got %0d exp 11", we_cnt - b); end
    n_tests++; if (pe_cnt - pb !== 1) begin n_fail++; $display("FAIL rs_err_count got %0d exp 1", pe_cnt - pb); end
    n_tests++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL rs_ready got %b exp 1", frame_ready); end
    n_tests++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL rs_frame_cnt got %0d exp 1", frame_cnt); end
    ack_pulse();
  endtask

  task automatic test_async_reset();
    int b;
    do_reset();
    for (int a = 0; a < 8; a++) wr(a, 16'h001F);
    idle(3);
    ack_pulse();
    for (int a = 0; a < 4; a++) wr(a, 16'hFFFF);
    reset = 1'b0;
    #1;
    b = we_cnt;
    n_tests++; if (gray_we !== 1'b0 || gray_data !== 8'd0 || gray_addr !== 3'd0) begin n_fail++; $display("FAIL ar_outputs got we=%b data=%0d addr=%0d exp 0", gray_we, gray_data, gray_addr); end
    n_tests++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL ar_frame_cnt got %0d exp 0", frame_cnt); end
    n_tests++; if (frame_ready !== 1'b0 || pix_err !== 1'b0) begin n_fail++; $display("FAIL ar_flags got rdy=%b err=%b exp 0", frame_ready, pix_err); end
    repeat (3) cyc();
    reset = 1'b1;
    idle(4);
    n_tests++; if (we_cnt - b !== 0) begin n_fail++; $display("FAIL ar_no_trailing got %0d exp 0", we_cnt - b); end
    wr(0, 16'hFFFF);
    idle(2);
    n_tests++; if (we_cnt - b !== 1) begin n_fail++; $display("FAIL ar_rearm got %0d exp 1", we_cnt - b); end
    n_tests++; if (log_q.size() == 0 || log_q[log_q.size()-1] !== {3'd0, exp_gray(255)}) begin n_fail++; $display("FAIL ar_rearm_pixel got %h exp %h", (log_q.size() > 0) ? log_q[log_q.size()-1] : 11'h7FF, {3'd0, exp_gray(255)}); end
  endtask

  task automatic test_frame_cnt_wrap();
    do_reset();
    frame_ack = 1'b1;
    for (int f = 0; f < 300; f++) begin
      for (int a = 0; a < 8; a++) wr(a, 16'h0000);
      idle(1);
      if (f == 255) begin
        n_tests++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_256 got %0d exp 0", frame_cnt); end
      end
    end
    frame_ack = 1'b0;
    n_tests++; if (frame_cnt !== 8'd44) begin n_fail++; $display("FAIL wrap_300 got %0d exp 44", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_colour_lut();
    test_full_frame();
    test_ack_on_entry();
    test_discontinuity();
    test_restart();
    test_async_reset();
    test_frame_cnt_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
